// File: rtl/minmax_pkg.sv
// Shared types and comparison helpers for the streaming min/max sequencer.
// Helpers work on values zero-extended to MAX_W bits; w gives the live width.
package minmax_pkg;

  typedef enum logic [1:0] {COLLECT, EVAL, OUT} state_t;

  localparam int MAX_W = 32;

  // Padding that can never win against a real element of the same chunk.
  function automatic logic [MAX_W-1:0] neutral_val(input logic us_sel,
                                                   input logic min_max_sel,
                                                   input int   w);
    logic [MAX_W-1:0] ones;
    logic [MAX_W-1:0] msb;
    ones = (MAX_W'(1) << w) - MAX_W'(1);
    msb  = MAX_W'(1) << (w - 1);
    case ({us_sel, min_max_sel})
      2'b00:   return ones;
      2'b01:   return '0;
      2'b10:   return ones >> 1;
      default: return msb;
    endcase
  endfunction

  // Strict comparison; signed operands are biased by flipping the sign bit.
  function automatic logic better(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input logic us_sel,
                                  input logic min_max_sel,
                                  input int   w);
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] ka;
    logic [MAX_W-1:0] kb;
    msb = MAX_W'(1) << (w - 1);
    ka  = us_sel ? (a ^ msb) : a;
    kb  = us_sel ? (b ^ msb) : b;
    return min_max_sel ? (ka > kb) : (ka < kb);
  endfunction

endpackage

// File: rtl/minmax_stream_ctrl_if.sv
// Element stream in, one result per vector out, plus per-vector config.
interface minmax_stream_ctrl_if #(
  parameter int W     = 12,
  parameter int GIDXW = 8,
  parameter int CNTW  = 9
);
  logic            cfg_us_sel;
  logic            cfg_min_max_sel;
  logic            s_valid;
  logic            s_ready;
  logic [W-1:0]    s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [W-1:0]    m_result;
  logic [GIDXW-1:0] m_index;
  logic [CNTW-1:0] m_count;
  logic            m_trunc;

  modport master (
    output cfg_us_sel, cfg_min_max_sel, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_result, m_index, m_count, m_trunc
  );

  modport slave (
    input  cfg_us_sel, cfg_min_max_sel, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_result, m_index, m_count, m_trunc
  );
endinterface

// File: rtl/minmax_stream_ctrl_minmax.sv
// Combinational min/max over NI packed elements; lowest index wins ties.
module minmax
  import minmax_pkg::*;
#(
  parameter int W  = 12,
  parameter int NI = 9
) (
  input  logic [NI*W-1:0]        x,
  input  logic                   us_sel,
  input  logic                   min_max_sel,
  output logic [W-1:0]           result,
  output logic [$clog2(NI)-1:0]  index
);
  localparam int IDXW = $clog2(NI);

  always_comb begin
    result = x[0 +: W];
    index  = '0;
    for (int k = 1; k < NI; k++) begin
      if (better(MAX_W'(x[k*W +: W]), MAX_W'(result), us_sel, min_max_sel, W)) begin
        result = x[k*W +: W];
        index  = IDXW'(k);
      end
    end
  end
endmodule

// File: rtl/minmax_stream_ctrl.sv
// Streams a vector through NI-wide chunks of the minmax datapath and returns
// the best value, its position, the element count and a truncation flag.
module minmax_stream_ctrl
  import minmax_pkg::*;
#(
  parameter int W      = 12,
  parameter int NI     = 9,
  parameter int MAXLEN = 256,
  parameter int IDXW   = $clog2(NI),
  parameter int GIDXW  = $clog2(MAXLEN),
  parameter int CNTW   = $clog2(MAXLEN+1)
) (
  input logic                clk,
  input logic                rst,
  minmax_stream_ctrl_if.slave bus
);
  state_t                 state;
  logic [NI-1:0][W-1:0]   chunk_q;
  logic [NI-1:0]          slot_vld;
  logic [IDXW-1:0]        slot;
  logic [CNTW-1:0]        elem_cnt;
  logic [CNTW-1:0]        chunk_base;
  logic                   chunk_seen;
  logic                   last_chunk;
  logic                   trunc_pend;
  logic                   us_q;
  logic                   mm_q;
  logic [W-1:0]           best_val;
  logic [GIDXW-1:0]       best_idx;

  logic                   rdy_q;
  logic                   vld_q;
  logic [W-1:0]           res_q;
  logic [GIDXW-1:0]       idx_q;
  logic [CNTW-1:0]        cnt_q;
  logic                   trunc_q;

  assign bus.s_ready  = rdy_q;
  assign bus.m_valid  = vld_q;
  assign bus.m_result = res_q;
  assign bus.m_index  = idx_q;
  assign bus.m_count  = cnt_q;
  assign bus.m_trunc  = trunc_q;

  logic            acc;
  logic [CNTW-1:0] elem_next;
  logic            hit_max;
  logic            chunk_full;

  assign acc        = bus.s_valid && rdy_q;
  assign elem_next  = elem_cnt + CNTW'(1);
  assign hit_max    = (elem_next == CNTW'(MAXLEN));
  assign chunk_full = (slot == IDXW'(NI-1));

  logic [W-1:0]      neutral;
  logic [NI*W-1:0]   mm_x;
  logic [W-1:0]      mm_res;
  logic [IDXW-1:0]   mm_idx;
  logic [GIDXW-1:0]  mm_gidx;
  logic              take;
  logic [W-1:0]      nb_val;
  logic [GIDXW-1:0]  nb_idx;

  assign neutral = W'(neutral_val(us_q, mm_q, W));

  always_comb begin
    mm_x = '0;
    for (int k = 0; k < NI; k++)
      mm_x[k*W +: W] = slot_vld[k] ? chunk_q[k] : neutral;
  end

  minmax #(.W(W), .NI(NI)) u_minmax (
    .x           (mm_x),
    .us_sel      (us_q),
    .min_max_sel (mm_q),
    .result      (mm_res),
    .index       (mm_idx)
  );

  // Later chunks must be strictly better so the earliest position keeps ties.
  assign mm_gidx = GIDXW'(chunk_base + CNTW'(mm_idx));
  assign take    = !chunk_seen ||
                   better(MAX_W'(mm_res), MAX_W'(best_val), us_q, mm_q, W);
  assign nb_val  = take ? mm_res  : best_val;
  assign nb_idx  = take ? mm_gidx : best_idx;

  always_ff @(posedge clk) begin
    if (acc) chunk_q[slot] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      rdy_q      <= 1'b1;
      vld_q      <= 1'b0;
      res_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      trunc_q    <= 1'b0;
      slot       <= '0;
      slot_vld   <= '0;
      elem_cnt   <= '0;
      chunk_base <= '0;
      chunk_seen <= 1'b0;
      last_chunk <= 1'b0;
      trunc_pend <= 1'b0;
      us_q       <= 1'b0;
      mm_q       <= 1'b0;
      best_val   <= '0;
      best_idx   <= '0;
    end else begin
      case (state)
        COLLECT: if (acc) begin
          slot_vld[slot] <= 1'b1;
          elem_cnt       <= elem_next;
          if (elem_cnt == '0) begin
            us_q <= bus.cfg_us_sel;
            mm_q <= bus.cfg_min_max_sel;
          end
          if (chunk_full || bus.s_last || hit_max) begin
            state      <= EVAL;
            rdy_q      <= 1'b0;
            slot       <= '0;
            last_chunk <= bus.s_last || hit_max;
            trunc_pend <= hit_max && !bus.s_last;
          end else begin
            slot <= slot + IDXW'(1);
          end
        end
        EVAL: begin
          slot_vld <= '0;
          if (last_chunk) begin
            state      <= OUT;
            vld_q      <= 1'b1;
            res_q      <= nb_val;
            idx_q      <= nb_idx;
            cnt_q      <= elem_cnt;
            trunc_q    <= trunc_pend;
            elem_cnt   <= '0;
            chunk_base <= '0;
            chunk_seen <= 1'b0;
          end else begin
            state      <= COLLECT;
            rdy_q      <= 1'b1;
            best_val   <= nb_val;
            best_idx   <= nb_idx;
            chunk_seen <= 1'b1;
            chunk_base <= chunk_base + CNTW'(NI);
          end
        end
        OUT: if (bus.m_ready) begin
          state   <= COLLECT;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
          trunc_q <= 1'b0;
        end
        default: begin
          state <= COLLECT;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_minmax_stream_ctrl.sv
// Drives vectors from a table into two instances (MAXLEN 256 and 16) and
// scores each result against expectations queued when the vector is sent.
module tb_minmax_stream_ctrl;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sel, s_valid, s_last, cus, cmm, m_ready;
  logic [W-1:0] s_data;

  minmax_stream_ctrl_if #(.W(W), .GIDXW(8), .CNTW(9)) ifa ();
  minmax_stream_ctrl_if #(.W(W), .GIDXW(4), .CNTW(5)) ifb ();

  minmax_stream_ctrl #(.W(W), .NI(9), .MAXLEN(256)) dut (
    .clk(clk), .rst(rst), .bus(ifa));
  minmax_stream_ctrl #(.W(W), .NI(9), .MAXLEN(16)) dut16 (
    .clk(clk), .rst(rst), .bus(ifb));

  assign ifa.s_valid         = s_valid & ~sel;
  assign ifb.s_valid         = s_valid & sel;
  assign ifa.s_data          = s_data;
  assign ifb.s_data          = s_data;
  assign ifa.s_last          = s_last;
  assign ifb.s_last          = s_last;
  assign ifa.cfg_us_sel      = cus;
  assign ifb.cfg_us_sel      = cus;
  assign ifa.cfg_min_max_sel = cmm;
  assign ifb.cfg_min_max_sel = cmm;
  assign ifa.m_ready         = m_ready & ~sel;
  assign ifb.m_ready         = m_ready & sel;

  logic         rdy, m_valid, m_trunc;
  logic [W-1:0] m_result;
  logic [7:0]   m_index;
  logic [8:0]   m_count;
  assign rdy      = sel ? ifb.s_ready  : ifa.s_ready;
  assign m_valid  = sel ? ifb.m_valid  : ifa.m_valid;
  assign m_trunc  = sel ? ifb.m_trunc  : ifa.m_trunc;
  assign m_result = sel ? ifb.m_result : ifa.m_result;
  assign m_index  = sel ? {4'b0, ifb.m_index} : ifa.m_index;
  assign m_count  = sel ? {4'b0, ifb.m_count} : ifa.m_count;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    bit   sel; bit us; bit mm; int len; bit last;
    logic [W-1:0] d [24];
    int er; int ei; int ec; int et;
  } vec_t;
  vec_t tbl [11];

  typedef struct { int r; int i; int c; int t; } exp_t;
  exp_t q [$];
  int out_edge = -1;

  task automatic set(input int n, input bit sl, input bit us, input bit mm,
                     input int len, input bit last,
                     input int er, input int ei, input int ec, input int et);
    tbl[n].sel = sl; tbl[n].us = us; tbl[n].mm = mm;
    tbl[n].len = len; tbl[n].last = last;
    tbl[n].er = er; tbl[n].ei = ei; tbl[n].ec = ec; tbl[n].et = et;
    for (int k = 0; k < 24; k++) tbl[n].d[k] = '0;
  endtask

  // Output scoreboard: compare on every accepted result.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && m_valid && m_ready) begin
      out_edge = cyc + 1;
      if (q.size() == 0) chk("sb_unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_result", int'(m_result), e.r);
        chk("sb_index",  int'(m_index),  e.i);
        chk("sb_count",  int'(m_count),  e.c);
        chk("sb_trunc",  int'(m_trunc),  e.t);
      end
    end
  end

  task automatic send_vec(input int n, output int first_edge, output int last_edge,
                          output int stalls, output int stall_pos);
    exp_t e;
    int t;
    e.r = tbl[n].er; e.i = tbl[n].ei; e.c = tbl[n].ec; e.t = tbl[n].et;
    q.push_back(e);
    stalls = 0; stall_pos = 0; first_edge = -1; last_edge = -1;
    for (int k = 0; k < tbl[n].len; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = tbl[n].d[k];
      s_last  = tbl[n].last && (k == tbl[n].len - 1);
      cus     = tbl[n].us;
      cmm     = tbl[n].mm;
      t = 0;
      while (!rdy && t < 50) begin
        if (k > 0) begin stalls++; stall_pos += k; end
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("send_timeout", t, 0);
      if (k == 0) first_edge = cyc + 1;
      last_edge = cyc + 1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 30) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe, le, st, sp, k;
    int lst [4];
    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cus = 1'b0; cmm = 1'b0; m_ready = 1'b1;

    set(0, 0, 0, 0, 5, 1, 7, 1, 5, 0);
    tbl[0].d[0] = 100; tbl[0].d[1] = 7; tbl[0].d[2] = 300; tbl[0].d[3] = 7; tbl[0].d[4] = 50;
    set(1, 0, 1, 1, 20, 1, 12'h7FF, 13, 20, 0);
    for (int i = 0; i < 20; i++) tbl[1].d[i] = 12'(12'h800 + i*3);
    tbl[1].d[13] = 12'h7FF; tbl[1].d[17] = 12'h7FF;
    set(2, 0, 0, 0, 1, 1, 12'hFFF, 0, 1, 0);
    tbl[2].d[0] = 12'hFFF;
    set(3, 0, 1, 0, 1, 1, 12'h800, 0, 1, 0);
    tbl[3].d[0] = 12'h800;
    set(4, 0, 0, 1, 3, 1, 3, 0, 3, 0);
    tbl[4].d[0] = 3; tbl[4].d[1] = 1; tbl[4].d[2] = 2;
    set(5, 0, 1, 1, 2, 1, 1, 0, 2, 0);
    tbl[5].d[0] = 12'h001; tbl[5].d[1] = 12'hFFF;
    set(6, 1, 0, 1, 16, 0, 12'hABC, 3, 16, 1);
    for (int i = 0; i < 16; i++) tbl[6].d[i] = 12'(i);
    tbl[6].d[3] = 12'hABC;
    set(7, 1, 0, 1, 4, 1, 19, 3, 4, 0);
    for (int i = 0; i < 4; i++) tbl[7].d[i] = 12'(16 + i);
    set(8, 0, 0, 0, 3, 1, 2, 1, 3, 0);
    tbl[8].d[0] = 5; tbl[8].d[1] = 2; tbl[8].d[2] = 9;
    set(9, 0, 1, 0, 11, 1, 12'hFFD, 2, 11, 0);
    for (int i = 0; i < 11; i++) tbl[9].d[i] = 12'(i + 1);
    tbl[9].d[2] = 12'hFFD; tbl[9].d[10] = 12'hFFD;
    set(10, 0, 0, 1, 9, 1, 500, 8, 9, 0);
    for (int i = 0; i < 9; i++) tbl[10].d[i] = 12'(i + 1);
    tbl[10].d[8] = 500;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_m_valid",  int'(m_valid),  0);
    chk("rst_s_ready",  int'(rdy),      1);
    chk("rst_m_result", int'(m_result), 0);
    chk("rst_m_index",  int'(m_index),  0);
    chk("rst_m_count",  int'(m_count),  0);
    chk("rst_m_trunc",  int'(m_trunc),  0);

    // Latency: EVAL in the cycle after the last accept, result the next.
    send_vec(0, fe, le, st, sp);
    chk("t1_eval_m_valid", int'(m_valid), 0);
    chk("t1_eval_s_ready", int'(rdy), 0);
    @(negedge clk);
    chk("t1_out_m_valid", int'(m_valid), 1);
    drain();

    send_vec(1, fe, le, st, sp);
    chk("t2_bubbles", st, 2);
    chk("t2_bubble_pos", sp, 27);
    drain();

    lst[0] = 2; lst[1] = 3; lst[2] = 9; lst[3] = 10;
    for (int i = 0; i < 4; i++) begin
      send_vec(lst[i], fe, le, st, sp);
      drain();
    end

    // Back-pressure in OUT, then a config change taking effect next vector.
    m_ready = 1'b0;
    send_vec(4, fe, le, st, sp);
    k = 0;
    while (!m_valid && k < 10) begin @(negedge clk); k++; end
    chk("t4_wait_m_valid", int'(m_valid), 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("t4_hold_m_valid",  int'(m_valid),  1);
      chk("t4_hold_m_result", int'(m_result), 3);
      chk("t4_hold_m_index",  int'(m_index),  0);
      chk("t4_hold_m_count",  int'(m_count),  3);
      chk("t4_hold_s_ready",  int'(rdy),      0);
    end
    cus = 1'b1; cmm = 1'b1;
    m_ready = 1'b1;
    send_vec(5, fe, le, st, sp);
    chk("t4_next_accept_edge", fe, out_edge + 1);
    drain();

    sel = 1'b1;
    send_vec(6, fe, le, st, sp);
    send_vec(7, fe, le, st, sp);
    drain();
    sel = 1'b0;

    // Reset mid-vector drops the partial vector and its config.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 12'(i + 1); s_last = 1'b0; cus = 1'b1; cmm = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_m_valid", int'(m_valid), 0);
    chk("t6_rst_s_ready", int'(rdy), 1);
    @(negedge clk);
    chk("t6_post_m_valid", int'(m_valid), 0);
    chk("t6_post_s_ready", int'(rdy), 1);
    send_vec(8, fe, le, st, sp);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
